nand_flash_responder: RTL and testbench

NAND_FLASH_RESPONDER -- requirements
Module: nand_flash_responder

---
 rtl/nfc_flash_defs.sv | 31 +++
 rtl/nfc_strobe_sync.sv | 49 ++++
 rtl/nand_flash_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_nand_flash_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/nfc_flash_defs.sv
// Shared NAND flash definitions: state encodings, command codes and the status byte format.
// Used by both this responder and the flash controller.
package nfc_flash_defs;

   localparam int COL_W = 5;
   localparam int ROW_W = 16;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_RD_ADDR   = 4'd1,
      ST_RD_WAIT30 = 4'd2,
      ST_RD_BUSY   = 4'd3,
      ST_RD_OUT    = 4'd4,
      ST_PG_ADDR   = 4'd5,
      ST_PG_DATA   = 4'd6,
      ST_PG_BUSY   = 4'd7,
      ST_RST_BUSY  = 4'd8
   } nfc_state_t;

   localparam logic [7:0] CMD_READ    = 8'h00;
   localparam logic [7:0] CMD_READ_GO = 8'h30;
   localparam logic [7:0] CMD_PROG    = 8'h80;
   localparam logic [7:0] CMD_PROG_GO = 8'h10;
   localparam logic [7:0] CMD_STATUS  = 8'h70;
   localparam logic [7:0] CMD_RESET   = 8'hFF;

   function automatic logic [7:0] status_byte(input logic ready);
      return {1'b0, ready, 6'b000000};
   endfunction

endpackage

// File: rtl/nfc_strobe_sync.sv
// Registers the flash bus and strobes, then decodes WE# rising edges into command,
// address and data latch events using the registered bus values.
module nfc_strobe_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] io_in,
   input  logic       cle,
   input  logic       ale,
   input  logic       wen,
   input  logic       ren,
   output logic [7:0] io_s,
   output logic       cmd_s,
   output logic       addr_s,
   output logic       data_s,
   output logic       ren_rise_s
);

   logic [7:0] io_r;
   logic       cle_r;
   logic       ale_r;
   logic       wen_r;
   logic       ren_r;
   logic       latch_s;

   // one-cycle history of the controller-driven pins
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         io_r  <= 8'h00;
         cle_r <= 1'b0;
         ale_r <= 1'b0;
         wen_r <= 1'b1;
         ren_r <= 1'b1;
      end else begin
         io_r  <= io_in;
         cle_r <= cle;
         ale_r <= ale;
         wen_r <= wen;
         ren_r <= ren;
      end
   end

   assign latch_s    = !wen_r && wen;
   assign io_s       = io_r;
   assign cmd_s      = latch_s &&  cle_r && !ale_r;
   assign addr_s     = latch_s && !cle_r &&  ale_r;
   assign data_s     = latch_s && !cle_r && !ale_r;
   assign ren_rise_s = !ren_r && ren;

endmodule

// File: rtl/nand_flash_responder.sv
// Behavioural NAND flash device: page read (00h/30h), page program (80h/10h), status (70h)
// and reset (FFh), backed by an external byte-wide array through a one-page buffer.
module nand_flash_responder
   import nfc_flash_defs::*;
#(
   parameter int PAGE_BYTES   = 32,
   parameter int BUSY_EXTRA   = 4,
   parameter int RESET_CYCLES = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             F_IO_in,
   output logic [7:0]             F_IO_out,
   output logic                   F_IO_oe,
   input  logic                   F_CLE,
   input  logic                   F_ALE,
   input  logic                   F_WEN,
   input  logic                   F_REN,
   output logic                   F_RB,
   output logic [ROW_W+COL_W-1:0] mem_addr,
   output logic [7:0]             mem_wdata,
   output logic                   mem_we,
   output logic                   mem_re,
   input  logic [7:0]             mem_rdata
);

   localparam logic [7:0] LAST_COL = 8'(PAGE_BYTES - 1);
   localparam logic [7:0] RD_DONE  = 8'(PAGE_BYTES + BUSY_EXTRA);
   localparam logic [7:0] PG_DONE  = 8'(PAGE_BYTES - 1 + BUSY_EXTRA);
   localparam logic [7:0] RST_DONE = 8'(RESET_CYCLES - 1);

   nfc_state_t             state_r;
   logic                   rb_r;
   logic                   status_r;
   logic                   oe_r;
   logic [7:0]             out_r;
   logic [7:0]             cnt_r;
   logic [1:0]             addr_idx_r;
   logic [COL_W-1:0]       col_r;
   logic [ROW_W-1:0]       row_r;
   logic [ROW_W+COL_W-1:0] mem_addr_r;
   logic [7:0]             mem_wdata_r;
   logic                   mem_we_r;
   logic                   mem_re_r;
   logic                   re_d_r;
   logic [COL_W-1:0]       cap_col_r;
   logic [7:0]             page_r [PAGE_BYTES];

   logic [7:0]       io_s;
   logic             cmd_s;
   logic             addr_s;
   logic             data_s;
   logic             ren_rise_s;
   logic [COL_W-1:0] next_col_s;
   logic             fill_s;
   logic             wr_s;
   logic             cap_s;

   nfc_strobe_sync u_sync (
      .clk        (clk),
      .rst        (rst),
      .io_in      (F_IO_in),
      .cle        (F_CLE),
      .ale        (F_ALE),
      .wen        (F_WEN),
      .ren        (F_REN),
      .io_s       (io_s),
      .cmd_s      (cmd_s),
      .addr_s     (addr_s),
      .data_s     (data_s),
      .ren_rise_s (ren_rise_s)
   );

   assign next_col_s = cnt_r[COL_W-1:0] + 5'd1;
   assign fill_s = cmd_s && rb_r && (io_s == CMD_PROG) &&
                   ((state_r == ST_IDLE) || (state_r == ST_RD_OUT));
   assign wr_s   = data_s && rb_r && (state_r == ST_PG_DATA);
   assign cap_s  = re_d_r && (state_r == ST_RD_BUSY);

   // page buffer: FFh fill on 80h, controller data bytes, array read capture
   always_ff @(posedge clk) begin
      if (fill_s) begin
         for (int i = 0; i < PAGE_BYTES; i++) page_r[i] <= 8'hFF;
      end else if (wr_s) begin
         page_r[col_r] <= io_s;
      end else if (cap_s) begin
         page_r[cap_col_r] <= mem_rdata;
      end
   end

   // operation sequencer with registered bus, ready/busy and array outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         rb_r        <= 1'b1;
         status_r    <= 1'b0;
         oe_r        <= 1'b0;
         out_r       <= 8'h00;
         cnt_r       <= 8'd0;
         addr_idx_r  <= 2'd0;
         col_r       <= 5'd0;
         row_r       <= 16'd0;
         mem_addr_r  <= 21'd0;
         mem_wdata_r <= 8'h00;
         mem_we_r    <= 1'b0;
         mem_re_r    <= 1'b0;
         re_d_r      <= 1'b0;
         cap_col_r   <= 5'd0;
      end else begin
         mem_we_r  <= 1'b0;
         mem_re_r  <= 1'b0;
         re_d_r    <= mem_re_r;
         cap_col_r <= mem_addr_r[COL_W-1:0];

         case (state_r)
            ST_RD_BUSY: begin
               mem_re_r                   <= (cnt_r < LAST_COL);
               mem_addr_r[COL_W-1:0]      <= next_col_s;
               if (cnt_r == RD_DONE) begin
                  state_r <= ST_RD_OUT;
                  rb_r    <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            ST_PG_BUSY: begin
               mem_we_r              <= (cnt_r < LAST_COL);
               mem_addr_r[COL_W-1:0] <= next_col_s;
               mem_wdata_r           <= page_r[next_col_s];
               if (cnt_r == PG_DONE) begin
                  state_r <= ST_IDLE;
                  rb_r    <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            ST_RST_BUSY: begin
               if (cnt_r == RST_DONE) begin
                  state_r <= ST_IDLE;
                  rb_r    <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            ST_RD_OUT: begin
               if (ren_rise_s && !status_r) col_r <= col_r + 5'd1;
            end
            default: ;
         endcase

         // address cycles: column, row low, row high; later bytes fall on a state that ignores them
         if (addr_s && rb_r && ((state_r == ST_RD_ADDR) || (state_r == ST_PG_ADDR))) begin
            addr_idx_r <= addr_idx_r + 2'd1;
            case (addr_idx_r)
               2'd0:    col_r       <= io_s[COL_W-1:0];
               2'd1:    row_r[7:0]  <= io_s;
               default: begin
                  row_r[15:8] <= io_s;
                  state_r     <= (state_r == ST_RD_ADDR) ? ST_RD_WAIT30 : ST_PG_DATA;
               end
            endcase
         end

         if (wr_s) col_r <= col_r + 5'd1;

         // while busy only status and reset are honoured
         if (cmd_s && (rb_r || (io_s == CMD_STATUS) || (io_s == CMD_RESET))) begin
            status_r <= (io_s == CMD_STATUS);
            case (io_s)
               CMD_READ, CMD_PROG: begin
                  addr_idx_r <= 2'd0;
                  if ((state_r == ST_IDLE) || (state_r == ST_RD_OUT))
                     state_r <= (io_s == CMD_READ) ? ST_RD_ADDR : ST_PG_ADDR;
                  else
                     state_r <= ST_IDLE;
               end
               CMD_READ_GO: begin
                  if (state_r == ST_RD_WAIT30) begin
                     state_r    <= ST_RD_BUSY;
                     rb_r       <= 1'b0;
                     cnt_r      <= 8'd0;
                     mem_re_r   <= 1'b1;
                     mem_addr_r <= {row_r, 5'd0};
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
               CMD_PROG_GO: begin
                  if (state_r == ST_PG_DATA) begin
                     state_r     <= ST_PG_BUSY;
                     rb_r        <= 1'b0;
                     cnt_r       <= 8'd0;
                     mem_we_r    <= 1'b1;
                     mem_addr_r  <= {row_r, 5'd0};
                     mem_wdata_r <= page_r[0];
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
               CMD_STATUS: ;
               CMD_RESET: begin
                  state_r  <= ST_RST_BUSY;
                  rb_r     <= 1'b0;
                  cnt_r    <= 8'd0;
                  mem_we_r <= 1'b0;
                  mem_re_r <= 1'b0;
               end
               default: state_r <= ST_IDLE;
            endcase
         end

         oe_r  <= status_r || (state_r == ST_RD_OUT);
         out_r <= status_r ? status_byte(rb_r) :
                  ((state_r == ST_RD_OUT) ? page_r[col_r] : 8'h00);
      end
   end

   // the bus is released immediately on RE# high or a RE#/WE# conflict
   assign F_IO_oe   = oe_r && !F_REN && F_WEN;
   assign F_IO_out  = out_r;
   assign F_RB      = rb_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign mem_we    = mem_we_r;
   assign mem_re    = mem_re_r;

endmodule

// File: tb/tb_nand_flash_responder.sv
// Bench for nand_flash_responder: a byte-array model behind the mem port, scoreboards of
// expected read bytes and array writes, one task per scenario.
module tb_nand_flash_responder;
   import nfc_flash_defs::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  F_IO_in;
   logic [7:0]  F_IO_out;
   logic        F_IO_oe;
   logic        F_CLE, F_ALE, F_WEN, F_REN;
   logic        F_RB;
   logic [20:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  mem [logic [20:0]];
   logic [28:0] obs_q [$];
   logic [28:0] exp_q [$];
   logic [7:0]  rd_exp_q [$];

   always #5 clk = ~clk;

   nand_flash_responder #(.PAGE_BYTES(32), .BUSY_EXTRA(4), .RESET_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .F_IO_in(F_IO_in), .F_IO_out(F_IO_out), .F_IO_oe(F_IO_oe),
      .F_CLE(F_CLE), .F_ALE(F_ALE), .F_WEN(F_WEN), .F_REN(F_REN), .F_RB(F_RB),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_re) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
   end

   always @(negedge clk) begin
      if (mem_we) begin
         mem[mem_addr] = mem_wdata;
         obs_q.push_back({mem_addr, mem_wdata});
      end
   end

   task automatic latch_byte(input logic c, input logic a, input logic [7:0] b);
      @(negedge clk); F_IO_in = b; F_CLE = c; F_ALE = a; F_WEN = 1'b0;
      @(negedge clk); F_WEN = 1'b1;
      @(negedge clk); F_CLE = 1'b0; F_ALE = 1'b0;
   endtask

   task automatic send_cmd(input logic [7:0] b);  latch_byte(1'b1, 1'b0, b); endtask
   task automatic send_addr(input logic [7:0] b); latch_byte(1'b0, 1'b1, b); endtask
   task automatic send_data(input logic [7:0] b); latch_byte(1'b0, 1'b0, b); endtask

   task automatic wait_ready(input int limit, output int low_cycles, output bit ok);
      low_cycles = 0;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (F_RB === 1'b1) begin
            ok = 1'b1;
            break;
         end
         low_cycles++;
         @(negedge clk);
      end
   endtask

   task automatic read_byte(output logic [7:0] v, output logic oe);
      @(negedge clk); F_REN = 1'b0;
      @(negedge clk);
      @(negedge clk);
      v  = F_IO_out;
      oe = F_IO_oe;
      F_REN = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (F_RB !== 1'b1)      begin n_bad++; $display("FAIL reset_rb got %b want 1", F_RB); end
      n_cmp++; if (F_IO_oe !== 1'b0)   begin n_bad++; $display("FAIL reset_oe got %b want 0", F_IO_oe); end
      n_cmp++; if (F_IO_out !== 8'h00) begin n_bad++; $display("FAIL reset_out got %h want 00", F_IO_out); end
      n_cmp++; if (mem_we !== 1'b0)    begin n_bad++; $display("FAIL reset_we got %b want 0", mem_we); end
      n_cmp++; if (mem_re !== 1'b0)    begin n_bad++; $display("FAIL reset_re got %b want 0", mem_re); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_read;
      int low; bit ok; logic [7:0] v, e; logic oe;
      mem[21'h00005] = 8'h3C; mem[21'h00006] = 8'h5D; mem[21'h00007] = 8'h7E;
      send_cmd(CMD_READ);
      send_addr(8'h05); send_addr(8'h00); send_addr(8'h00);
      send_cmd(CMD_READ_GO);
      rd_exp_q.push_back(8'h3C); rd_exp_q.push_back(8'h5D); rd_exp_q.push_back(8'h7E);
      wait_ready(200, low, ok);
      n_cmp++; if (!ok || low != 37) begin n_bad++; $display("FAIL read_busy_len got %0d (ready=%0b) want 37", low, ok); end
      repeat (2) @(negedge clk);
      while (rd_exp_q.size() > 0) begin
         read_byte(v, oe);
         e = rd_exp_q.pop_front();
         n_cmp++; if (v !== e || oe !== 1'b1) begin n_bad++; $display("FAIL read_data got %h oe=%b want %h oe=1", v, oe, e); end
      end
      n_cmp++; if (F_IO_oe !== 1'b0) begin n_bad++; $display("FAIL read_oe_ren_high got %b want 0", F_IO_oe); end
   endtask

   task automatic test_program;
      int low; bit ok; logic [7:0] d; logic [28:0] o, e;
      obs_q.delete();
      send_cmd(CMD_PROG);
      send_addr(8'h1F); send_addr(8'h02); send_addr(8'h00);
      send_data(8'h11); send_data(8'h22);
      for (int c = 0; c < 32; c++) begin
         d = (c == 31) ? 8'h11 : ((c == 0) ? 8'h22 : 8'hFF);
         exp_q.push_back({16'h0002, 5'(c), d});
      end
      send_cmd(CMD_PROG_GO);
      wait_ready(200, low, ok);
      n_cmp++; if (!ok || low != 36) begin n_bad++; $display("FAIL prog_busy_len got %0d (ready=%0b) want 36", low, ok); end
      n_cmp++; if (obs_q.size() != 32) begin n_bad++; $display("FAIL prog_write_count got %0d want 32", obs_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++; if (o !== e) begin n_bad++; $display("FAIL prog_write got addr %h data %h want addr %h data %h", o[28:8], o[7:0], e[28:8], e[7:0]); end
      end
      exp_q.delete();
   endtask

   task automatic test_read_wrap;
      int low; bit ok; logic [7:0] v, e; logic oe;
      send_cmd(CMD_READ);
      send_addr(8'h1F); send_addr(8'h02); send_addr(8'h00);
      send_cmd(CMD_READ_GO);
      rd_exp_q.push_back(8'h11); rd_exp_q.push_back(8'h22);
      wait_ready(200, low, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_ready got busy after %0d cycles want ready", low); end
      repeat (2) @(negedge clk);
      while (rd_exp_q.size() > 0) begin
         read_byte(v, oe);
         e = rd_exp_q.pop_front();
         n_cmp++; if (v !== e || oe !== 1'b1) begin n_bad++; $display("FAIL wrap_data got %h oe=%b want %h oe=1", v, oe, e); end
      end
   endtask

   task automatic test_status;
      int low; bit ok; logic [7:0] v; logic oe;
      send_cmd(CMD_PROG);
      send_addr(8'h00); send_addr(8'h03); send_addr(8'h00);
      send_data(8'hAB);
      send_cmd(CMD_PROG_GO);
      send_cmd(CMD_STATUS);
      read_byte(v, oe);
      n_cmp++; if (v !== 8'h00 || oe !== 1'b1) begin n_bad++; $display("FAIL status_busy got %h oe=%b want 00 oe=1", v, oe); end
      n_cmp++; if (F_RB !== 1'b0) begin n_bad++; $display("FAIL status_still_busy got rb=%b want 0", F_RB); end
      wait_ready(200, low, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL status_ready got busy after %0d cycles want ready", low); end
      repeat (2) @(negedge clk);
      read_byte(v, oe);
      n_cmp++; if (v !== 8'h40 || oe !== 1'b1) begin n_bad++; $display("FAIL status_ready_byte got %h oe=%b want 40 oe=1", v, oe); end
   endtask

   task automatic test_abort;
      int low, n_at, guard; bit ok;
      send_cmd(CMD_PROG);
      send_addr(8'h00); send_addr(8'h04); send_addr(8'h00);
      send_data(8'h99);
      obs_q.delete();
      send_cmd(CMD_PROG_GO);
      guard = 0;
      while (obs_q.size() < 10 && guard < 100) begin
         @(negedge clk); #1;
         guard++;
      end
      n_cmp++; if (obs_q.size() < 10) begin n_bad++; $display("FAIL abort_first_writes got %0d want 10", obs_q.size()); end
      send_cmd(CMD_RESET);
      #1;
      n_at = obs_q.size();
      wait_ready(50, low, ok);
      n_cmp++; if (!ok || low != 8) begin n_bad++; $display("FAIL abort_busy_len got %0d (ready=%0b) want 8", low, ok); end
      repeat (40) @(negedge clk);
      n_cmp++; if (obs_q.size() != n_at || n_at >= 32) begin n_bad++; $display("FAIL abort_no_more_we got %0d writes after abort (%0d before) want 0 and <32 before", obs_q.size() - n_at, n_at); end
      n_cmp++; if (dut.state_r !== ST_IDLE || F_RB !== 1'b1) begin n_bad++; $display("FAIL abort_idle got state %0d rb %b want %0d rb 1", dut.state_r, F_RB, ST_IDLE); end
   endtask

   task automatic test_unknown;
      bit went_busy;
      send_cmd(CMD_READ);
      n_cmp++; if (dut.state_r !== ST_RD_ADDR) begin n_bad++; $display("FAIL unknown_pre got state %0d want %0d", dut.state_r, ST_RD_ADDR); end
      send_cmd(8'h5A);
      went_busy = 1'b0;
      repeat (10) begin
         if (F_RB !== 1'b1) went_busy = 1'b1;
         @(negedge clk);
      end
      n_cmp++; if (dut.state_r !== ST_IDLE || went_busy) begin n_bad++; $display("FAIL unknown_cmd got state %0d busy %0b want %0d busy 0", dut.state_r, went_busy, ST_IDLE); end
   endtask

   task automatic test_reset_in_read_out;
      int low; bit ok;
      send_cmd(CMD_READ);
      send_addr(8'h05); send_addr(8'h00); send_addr(8'h00);
      send_cmd(CMD_READ_GO);
      wait_ready(200, low, ok);
      @(negedge clk); F_REN = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (F_IO_oe !== 1'b1 || !ok) begin n_bad++; $display("FAIL rdout_pre got oe=%b ready=%0b want oe=1 ready=1", F_IO_oe, ok); end
      rst = 1'b0;
      #1;
      n_cmp++; if (F_IO_oe !== 1'b0 || F_RB !== 1'b1 || F_IO_out !== 8'h00) begin n_bad++; $display("FAIL rdout_reset got oe=%b rb=%b out=%h want oe=0 rb=1 out=00", F_IO_oe, F_RB, F_IO_out); end
      @(negedge clk); rst = 1'b1; F_REN = 1'b1;
      @(negedge clk);
      n_cmp++; if (dut.state_r !== ST_IDLE || F_IO_oe !== 1'b0) begin n_bad++; $display("FAIL rdout_after got state %0d oe=%b want %0d oe=0", dut.state_r, F_IO_oe, ST_IDLE); end
   endtask

   initial begin
      rst = 1'b0; F_IO_in = 8'h00; F_CLE = 1'b0; F_ALE = 1'b0; F_WEN = 1'b1; F_REN = 1'b1;
      test_reset();
      test_read();
      test_program();
      test_read_wrap();
      test_status();
      test_abort();
      test_unknown();
      test_reset_in_read_out();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
